// File: rtl/tap_block_loader.sv
// rtl/tap_block_loader.sv - multi-block Oric .TAP parser streaming ioctl download bytes into RAM
module tap_block_loader #(
  parameter int MIN_SYNC   = 3,
  parameter int MAX_NAME   = 16,
  parameter int MAX_BLOCKS = 8,
  parameter int BC_W       = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ioctl_download,
  input  logic            ioctl_wr,
  input  logic [24:0]     ioctl_addr,
  input  logic [7:0]      ioctl_dout,
  output logic            tape_wr,
  output logic [15:0]     tape_addr,
  output logic [7:0]      tape_dout,
  output logic [15:0]     loadpoint,
  output logic            autostart,
  output logic            tape_complete,
  output logic            tape_autorun,
  output logic [BC_W-1:0] block_count,
  output logic [2:0]      tape_error
);

  localparam int SC_W = $clog2(MIN_SYNC + 1);
  localparam int NM_W = $clog2(MAX_NAME);

  typedef enum logic [2:0] {S_SYNC, S_HDR, S_NAME, S_DATA, S_DONE, S_ERR} state_t;

  state_t          state_q, state_d, cur;
  logic            dl_q, rise, fall, accept, restart;
  logic [SC_W-1:0] sync_cnt, sync_eff;
  logic [BC_W-1:0] bc_eff;
  logic [2:0]      err_eff;
  logic [3:0]      hdr_idx;
  logic [NM_W-1:0] name_cnt;
  logic [7:0]      autorun_q;
  logic [15:0]     start_q, end_q, cur_addr;
  logic            data_wr, blk_last, err_set, complete_set;
  logic [2:0]      err_code;

  assign rise    = ioctl_download & ~dl_q;
  assign fall    = ~ioctl_download & dl_q;
  assign accept  = ioctl_download & ioctl_wr;
  assign restart = rise | (accept && ioctl_addr == 25'd0);

  // Restart takes effect in the same cycle so an offset-0 byte is parsed from a clean slate.
  assign cur      = restart ? S_SYNC : state_q;
  assign sync_eff = restart ? '0 : sync_cnt;
  assign bc_eff   = restart ? '0 : block_count;
  assign err_eff  = restart ? 3'd0 : tape_error;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_SYNC;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = cur;
    if (accept) begin
      case (cur)
        S_SYNC: if (ioctl_dout == 8'h24 && sync_eff >= SC_W'(MIN_SYNC)) state_d = S_HDR;
        S_HDR:  if (hdr_idx == 4'd8) state_d = err_set ? S_ERR : S_NAME;
        S_NAME: begin
          if (ioctl_dout == 8'h00) state_d = S_DATA;
          else if (err_set)        state_d = S_ERR;
        end
        S_DATA: if (blk_last) state_d = (bc_eff == BC_W'(MAX_BLOCKS - 1)) ? S_DONE : S_SYNC;
        default: ;
      endcase
    end else if (fall && err_set) begin
      state_d = S_ERR;
    end
  end

  always_comb begin
    data_wr      = 1'b0;
    blk_last     = 1'b0;
    err_set      = 1'b0;
    err_code     = 3'd0;
    complete_set = 1'b0;
    if (accept) begin
      case (cur)
        S_HDR: if (hdr_idx == 4'd8 && end_q < start_q) begin
          err_set  = 1'b1;
          err_code = 3'd1;
        end
        S_NAME: if (ioctl_dout != 8'h00 && name_cnt == NM_W'(MAX_NAME - 1)) begin
          err_set  = 1'b1;
          err_code = 3'd2;
        end
        S_DATA: begin
          data_wr  = 1'b1;
          blk_last = (cur_addr == end_q);
        end
        default: ;
      endcase
    end else if (fall) begin
      case (state_q)
        S_HDR, S_NAME, S_DATA: begin
          err_set  = 1'b1;
          err_code = 3'd3;
        end
        S_SYNC: begin
          if (block_count == '0) begin
            err_set  = 1'b1;
            err_code = 3'd4;
          end else if (tape_error == 3'd0) begin
            complete_set = 1'b1;
          end
        end
        S_DONE: if (tape_error == 3'd0) complete_set = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_q          <= 1'b0;
      tape_wr       <= 1'b0;
      tape_addr     <= '0;
      tape_dout     <= '0;
      loadpoint     <= '0;
      autostart     <= 1'b0;
      tape_complete <= 1'b0;
      tape_autorun  <= 1'b0;
      block_count   <= '0;
      tape_error    <= 3'd0;
      sync_cnt      <= '0;
      hdr_idx       <= 4'd0;
      name_cnt      <= '0;
      autorun_q     <= 8'd0;
      start_q       <= 16'd0;
      end_q         <= 16'd0;
      cur_addr      <= 16'd0;
    end else begin
      dl_q         <= ioctl_download;
      tape_wr      <= data_wr;
      tape_autorun <= complete_set & autostart;
      if (restart) begin
        block_count   <= '0;
        tape_complete <= 1'b0;
        tape_error    <= 3'd0;
        autostart     <= 1'b0;
        loadpoint     <= '0;
        sync_cnt      <= '0;
      end
      if (accept) begin
        case (cur)
          S_SYNC: begin
            hdr_idx <= 4'd0;
            if (ioctl_dout == 8'h16)
              sync_cnt <= (sync_eff == SC_W'(MIN_SYNC)) ? sync_eff : sync_eff + 1'b1;
            else
              sync_cnt <= '0;
          end
          S_HDR: begin
            hdr_idx <= hdr_idx + 4'd1;
            case (hdr_idx)
              4'd3: autorun_q     <= ioctl_dout;
              4'd4: end_q[15:8]   <= ioctl_dout;
              4'd5: end_q[7:0]    <= ioctl_dout;
              4'd6: start_q[15:8] <= ioctl_dout;
              4'd7: begin
                start_q[7:0] <= ioctl_dout;
                if (bc_eff == '0) begin
                  loadpoint <= {start_q[15:8], ioctl_dout};
                  autostart <= (autorun_q != 8'd0);
                end
              end
              4'd8: begin
                cur_addr <= start_q;
                name_cnt <= '0;
              end
              default: ;
            endcase
          end
          S_NAME: name_cnt <= name_cnt + 1'b1;
          S_DATA: begin
            tape_addr <= cur_addr;
            tape_dout <= ioctl_dout;
            cur_addr  <= cur_addr + 16'd1;
            if (blk_last) begin
              block_count <= bc_eff + 1'b1;
              sync_cnt    <= '0;
            end
          end
          default: ;
        endcase
      end
      if (err_set && err_eff == 3'd0) tape_error <= err_code;
      if (complete_set) tape_complete <= 1'b1;
    end
  end

endmodule
